pipe_hazard_ctrl: RTL and testbench

Central hazard and stall controller for the 5-stage RV32 pipeline. It resolves load-use hazards, taken branches/jumps from EX, instruction-fetch and data-memory wait states, and multi-cycle mul/div occupancy of EX. It drives the stall/flush inputs of the F (PC), D, E, M and W pipeline registers. `d_flush` connects directly to the `jb` input of the D-stage register.

---
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central hazard/stall controller for the 5-stage RV32 pipeline.
//               Resolves load-use, EX redirects, imem/dmem wait states and
//               multi-cycle mul/div occupancy of EX, driving the stall/flush
//               controls of the F, D, E, M and W pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_is_muldiv,
    input  logic        ex_jb,
    input  logic        imem_ready,
    input  logic        mem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        d_stall,
    output logic        d_flush,
    output logic        e_stall,
    output logic        e_flush,
    output logic        m_stall,
    output logic        m_flush,
    output logic        w_flush,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    localparam int                 c_CNT_W    = $clog2(MD_LAT) + 1;
    localparam logic               c_MD_EN    = (MD_LAT > 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = (MD_LAT > 1) ? c_CNT_W'(MD_LAT - 2) : '0;

    localparam logic [0:0] c_ST_RUN     = 1'b0;
    localparam logic [0:0] c_ST_MD_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_stall_cycles;

    logic w_dmem_wait;
    logic w_load_use;
    logic w_md_hold;

    assign w_dmem_wait = mem_req & ~dmem_ready;

    assign w_load_use = ex_is_load & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));

    // A mul/div holds EX from its first cycle; the count then covers the
    // remaining hold cycles, and the cycle where it reaches zero releases EX.
    assign w_md_hold = ((r_state == c_ST_RUN) & ex_is_muldiv & c_MD_EN) |
                       ((r_state == c_ST_MD_BUSY) & (r_cnt != '0));

    assign md_busy      = (r_state == c_ST_MD_BUSY);
    assign stall_cycles = r_stall_cycles;

    // Strict-priority decode of the stall/flush controls; all quiet in reset.
    always_comb begin
        pc_stall = 1'b0;
        d_stall  = 1'b0;
        d_flush  = 1'b0;
        e_stall  = 1'b0;
        e_flush  = 1'b0;
        m_stall  = 1'b0;
        m_flush  = 1'b0;
        w_flush  = 1'b0;
        if (!rst) begin
            if (w_dmem_wait) begin
                // Freeze everything up to M; W takes a bubble.
                pc_stall = 1'b1;
                d_stall  = 1'b1;
                e_stall  = 1'b1;
                m_stall  = 1'b1;
                w_flush  = 1'b1;
            end else if (w_md_hold) begin
                pc_stall = 1'b1;
                d_stall  = 1'b1;
                e_stall  = 1'b1;
                m_flush  = 1'b1;
            end else if (ex_jb) begin
                // PC loads the redirect target, so it must not be held.
                d_flush  = 1'b1;
                e_flush  = 1'b1;
            end else if (w_load_use) begin
                pc_stall = 1'b1;
                d_stall  = 1'b1;
                e_flush  = 1'b1;
            end else if (!imem_ready) begin
                pc_stall = 1'b1;
                d_flush  = 1'b1;
            end
        end
    end

    // Mul/div occupancy FSM; frozen entirely while the data memory waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_cnt   <= '0;
        end else if (!w_dmem_wait) begin
            case (r_state)
                c_ST_RUN: begin
                    if (ex_is_muldiv && c_MD_EN) begin
                        r_cnt   <= c_CNT_INIT;
                        r_state <= c_ST_MD_BUSY;
                    end
                end
                c_ST_MD_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= c_ST_RUN;
                    end
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Performance counter of PC-stalled cycles; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
        end else if (pc_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Scoreboard bench for pipe_hazard_ctrl. Two instances
//               (MD_LAT=4 and MD_LAT=1) share one stimulus stream; expected
//               outputs come from an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_is_muldiv = 0;
    logic        ex_jb = 0, imem_ready = 1, mem_req = 0, dmem_ready = 1;

    // flags order: pc_stall,d_stall,d_flush,e_stall,e_flush,m_stall,m_flush,w_flush,md_busy
    logic [8:0]  got_f[2];
    logic [31:0] got_sc[2];

    typedef struct packed {
        logic [8:0]  f4;
        logic [31:0] sc4;
        logic [8:0]  f1;
        logic [31:0] sc1;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_is_muldiv(ex_is_muldiv), .ex_jb(ex_jb),
        .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_stall(got_f[0][8]), .d_stall(got_f[0][7]), .d_flush(got_f[0][6]),
        .e_stall(got_f[0][5]), .e_flush(got_f[0][4]), .m_stall(got_f[0][3]),
        .m_flush(got_f[0][2]), .w_flush(got_f[0][1]), .md_busy(got_f[0][0]),
        .stall_cycles(got_sc[0])
    );

    pipe_hazard_ctrl #(.MD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_is_muldiv(ex_is_muldiv), .ex_jb(ex_jb),
        .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_stall(got_f[1][8]), .d_stall(got_f[1][7]), .d_flush(got_f[1][6]),
        .e_stall(got_f[1][5]), .e_flush(got_f[1][4]), .m_stall(got_f[1][3]),
        .m_flush(got_f[1][2]), .w_flush(got_f[1][1]), .md_busy(got_f[1][0]),
        .stall_cycles(got_sc[1])
    );

    // Reference model, one slot per instance: whether a mul/div occupancy
    // window is open, how many non-frozen cycles it has spent in EX so far,
    // and the running count of PC-stalled cycles.
    int          lat_of[2] = '{4, 1};
    bit          m_win[2]  = '{0, 0};
    int          m_elap[2] = '{0, 0};
    logic [31:0] m_sc[2]   = '{32'd0, 32'd0};

    function automatic logic [8:0] model_flags(input int k);
        bit dw, lu, hold, pc, ds, df, es, ef, ms, mf, wf;
        int L;
        L  = lat_of[k];
        dw = mem_req && !dmem_ready;
        lu = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        hold = m_win[k] ? (m_elap[k] < L - 1) : (ex_is_muldiv && L > 1);
        {pc, ds, df, es, ef, ms, mf, wf} = '0;
        if (rst)               ;
        else if (dw)           {pc, ds, es, ms, wf} = '1;
        else if (hold)         {pc, ds, es, mf} = '1;
        else if (ex_jb)        {df, ef} = '1;
        else if (lu)           {pc, ds, ef} = '1;
        else if (!imem_ready)  {pc, df} = '1;
        return {pc, ds, df, es, ef, ms, mf, wf, (m_win[k] && !rst)};
    endfunction

    task automatic model_advance(input int k, input logic [8:0] f);
        int L;
        L = lat_of[k];
        if (rst) begin
            m_win[k] = 0; m_elap[k] = 0; m_sc[k] = 32'd0;
        end else begin
            if (f[8]) m_sc[k] = m_sc[k] + 32'd1;
            if (!(mem_req && !dmem_ready)) begin
                if (!m_win[k]) begin
                    if (ex_is_muldiv && L > 1) begin m_win[k] = 1; m_elap[k] = 1; end
                end else if (m_elap[k] == L - 1) m_win[k] = 0;
                else m_elap[k] = m_elap[k] + 1;
            end
        end
    endtask

    // One clock cycle: drive inputs after the edge, push expectations, step model.
    task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic md, input logic jb,
                       input logic im, input logic mr, input logic dr);
        exp_t e;
        logic [8:0] f4, f1;
        @(posedge clk); #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_is_load = ld; ex_is_muldiv = md; ex_jb = jb;
        imem_ready = im; mem_req = mr; dmem_ready = dr;
        f4 = model_flags(0);
        f1 = model_flags(1);
        e.f4 = f4; e.sc4 = rst ? 32'd0 : m_sc[0];
        e.f1 = f1; e.sc1 = rst ? 32'd0 : m_sc[1];
        q.push_back(e);
        model_advance(0, f4);
        model_advance(1, f1);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    endtask

    // Monitor: compare every presented output set against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                nvec++;
                if (got_f[0] !== e.f4 || got_sc[0] !== e.sc4) begin
                    nerr++;
                    $display("FAIL lat4 t=%0t flags=%b sc=%0d required flags=%b sc=%0d",
                             $time, got_f[0], got_sc[0], e.f4, e.sc4);
                end
                nvec++;
                if (got_f[1] !== e.f1 || got_sc[1] !== e.sc1) begin
                    nerr++;
                    $display("FAIL lat1 t=%0t flags=%b sc=%0d required flags=%b sc=%0d",
                             $time, got_f[1], got_sc[1], e.f1, e.sc1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then an idle cycle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle();
        // Load-use through rs2, then clear.
        cyc(0, 0, 5, 0, 1, 5, 1, 0, 0, 1, 0, 1);
        idle();
        // Load to x0 and unused matching source: no hazard.
        cyc(0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1);
        cyc(0, 7, 3, 0, 1, 7, 1, 0, 0, 1, 0, 1);
        // Redirect overrides imem wait, then plain imem wait.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        // Mul/div held four cycles.
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        idle();
        // Mul/div with a two-cycle dmem wait starting in cycle 2.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        idle();
        // dmem wait masks a redirect, which fires once memory is ready.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        idle();
        // Reset pulse in the middle of a mul/div window.
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        idle();
        // Randomised traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end
        idle();
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
